// File: rtl/iterative_shifter.sv
// Multi-cycle shift/rotate unit: shifts the working register by up to STEP bits per
// clock, with a start/done handshake so control can stall on busy_o.
module iterative_shifter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STEP       = 1,
  localparam int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  data_o
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // remaining never exceeds DATA_WIDTH-1, so clamping STEP there leaves min() unchanged
  localparam int unsigned StepClamp = (STEP >= DATA_WIDTH) ? DATA_WIDTH - 1 : STEP;
  localparam logic [SHAMT_WIDTH-1:0] StepK = SHAMT_WIDTH'(StepClamp);
  localparam logic [SHAMT_WIDTH:0]   DwK   = (SHAMT_WIDTH+1)'(DATA_WIDTH);

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [SHAMT_WIDTH-1:0] rem_q, rem_d;
  logic [1:0]             mode_q, mode_d;

  logic [SHAMT_WIDTH-1:0] k;
  logic [SHAMT_WIDTH:0]   rot_l;
  logic [DATA_WIDTH-1:0]  shifted;

  always_comb begin
    k       = (rem_q > StepK) ? StepK : rem_q;
    rot_l   = DwK - {1'b0, k};
    shifted = data_q;
    case (mode_q)
      2'b00:   shifted = data_q << k;
      2'b01:   shifted = data_q >> k;
      2'b11:   shifted = $signed(data_q) >>> k;
      2'b10:   shifted = (data_q >> k) | (data_q << rot_l);
      default: shifted = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          data_d  = data_i;
          rem_d   = shamt_i;
          mode_d  = mode_i;
          state_d = (shamt_i != '0) ? StShift : StDone;
        end
      end
      StShift: begin
        data_d = shifted;
        rem_d  = rem_q - k;
        if (rem_q == k) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);
  assign data_o = data_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Randomised and directed checks of iterative_shifter (STEP=1 and STEP=4 instances)
// against an arithmetic reference model of shift result and latency.
module tb_iterative_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic [1:0]  mode1 = '0, mode4 = '0;
  logic [31:0] din1 = '0, din4 = '0;
  logic [4:0]  sh1 = '0, sh4 = '0;
  logic        busy1, done1, busy4, done4;
  logic [31:0] dout1, dout4;

  logic        sel = 1'b0;
  logic        cur_busy, cur_done;
  logic [31:0] cur_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  iterative_shifter #(.DATA_WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start_i(start1), .mode_i(mode1), .data_i(din1),
    .shamt_i(sh1), .busy_o(busy1), .done_o(done1), .data_o(dout1)
  );

  iterative_shifter #(.DATA_WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start_i(start4), .mode_i(mode4), .data_i(din4),
    .shamt_i(sh4), .busy_o(busy4), .done_o(done4), .data_o(dout4)
  );

  assign cur_busy = sel ? busy4 : busy1;
  assign cur_done = sel ? done4 : done1;
  assign cur_data = sel ? dout4 : dout1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] d,
                                            input int s);
    logic [63:0] w;
    case (m)
      2'b00:   w = {32'b0, d} << s;
      2'b01:   w = {32'b0, d} >> s;
      2'b11:   w = {{32{d[31]}}, d} >> s;
      default: w = {d, d} >> s;
    endcase
    return w[31:0];
  endfunction

  task automatic drive(input logic s, input logic st, input logic [1:0] m,
                       input logic [31:0] d, input logic [4:0] a);
    if (s) begin start4 = st; mode4 = m; din4 = d; sh4 = a; end
    else   begin start1 = st; mode1 = m; din1 = d; sh1 = a; end
  endtask

  // One accepted operation; optionally hammer start_i while busy to prove it is ignored.
  task automatic run_op(input logic s, input logic [1:0] m, input logic [31:0] d,
                        input logic [4:0] a, input logic poke);
    int step, n, cnt, busy_hi;
    logic [31:0] exp;
    step = s ? 4 : 1;
    n    = (int'(a) + step - 1) / step;
    exp  = ref_shift(m, d, int'(a));
    sel  = s;
    @(negedge clk);
    drive(s, 1'b1, m, d, a);
    @(negedge clk);
    drive(s, 1'b0, $urandom, $urandom, $urandom);
    cnt = 0;
    busy_hi = 0;
    while (!cur_done && cnt < 100) begin
      if (cur_busy) busy_hi++;
      if (poke) drive(s, 1'b1, $urandom, $urandom, $urandom);
      @(negedge clk);
      cnt++;
    end
    if (cur_busy) busy_hi++;
    check_eq("latency", 64'(cnt), 64'(n));
    check_eq("result", {32'b0, cur_data}, {32'b0, exp});
    if (poke) drive(s, 1'b1, $urandom, $urandom, $urandom);
    @(negedge clk);
    drive(s, 1'b0, mode1, din1, sh1);
    check_eq("busy_cycles", 64'(busy_hi), 64'(n + 1));
    check_eq("done_single", {63'b0, cur_done}, 64'd0);
    check_eq("busy_fall", {63'b0, cur_busy}, 64'd0);
    @(negedge clk);
    check_eq("hold_result", {32'b0, cur_data}, {32'b0, exp});
  endtask

  initial begin
    #12;
    check_eq("rst_data", {32'b0, dout1}, 64'd0);
    check_eq("rst_busy", {63'b0, busy1}, 64'd0);
    check_eq("rst_done", {63'b0, done1}, 64'd0);
    reset = 1'b1;

    run_op(1'b0, 2'b00, 32'h0000_0001, 5'd31, 1'b0);
    run_op(1'b0, 2'b11, 32'h8000_0000, 5'd4, 1'b0);
    run_op(1'b0, 2'b10, 32'h1234_5678, 5'd8, 1'b0);
    run_op(1'b0, 2'b01, 32'h8000_0000, 5'd4, 1'b0);
    for (int m = 0; m < 4; m++) run_op(1'b0, 2'(m), 32'hDEAD_BEEF, 5'd0, 1'b0);
    run_op(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd7, 1'b0);
    run_op(1'b1, 2'b11, 32'h8000_0000, 5'd31, 1'b0);
    run_op(1'b0, 2'b10, 32'hA5A5_0F0F, 5'd9, 1'b1);
    run_op(1'b1, 2'b00, 32'h0000_0003, 5'd13, 1'b1);

    // Reset at E0+3 of a 20-bit shift aborts with no done pulse
    sel = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 32'h0000_0001, 5'd20);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("abort_data", {32'b0, dout1}, 64'd0);
    check_eq("abort_busy", {63'b0, busy1}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_done", {63'b0, done1}, 64'd0);
    end
    reset = 1'b1;
    run_op(1'b0, 2'b00, 32'h0000_0003, 5'd1, 1'b0);

    for (int i = 0; i < 60; i++)
      run_op(1'(i % 2), 2'($urandom), $urandom, 5'($urandom), 1'($urandom_range(0, 3) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/iterative_shifter.md
# iterative_shifter

Multi-cycle, parametrised shift unit for the MIPS datapath. It executes SLL/SRL/SRA and rotate-right on a `DATA_WIDTH`-bit operand. Each clock it shifts by up to `STEP` bit positions, trading latency for area against a full barrel shifter. It sits beside the ALU and uses a start/done handshake, so the control unit stalls on `busy_o` for shift instructions (including SLLV/SRLV/SRAV with a register-supplied amount).

## Interface
- `DATA_WIDTH`, 32, operand/result width; must be a power of two, ≥ 2.
- `STEP`, 1, maximum bit positions shifted per cycle; power of two, 1 ≤ `STEP` ≤ `DATA_WIDTH`.
- `SHAMT_WIDTH`, localparam = $clog2(`DATA_WIDTH`), shift-amount width (5 for 32-bit).

Ports:
- `clk`, in, 1, system clock; all state changes on rising edge.
- `reset`, in, 1, asynchronous, active-low reset.
- `start_i`, in, 1, request; sampled only in IDLE.
- `mode_i`, in, 2, operation: 00 SLL, 01 SRL, 11 SRA, 10 ROTR.
- `data_i`, in, `DATA_WIDTH`, operand; captured on accepted start.
- `shamt_i`, in, `SHAMT_WIDTH`, shift amount (0 … `DATA_WIDTH`-1); captured on accepted start.
- `busy_o`, out, 1, high in SHIFT and DONE.
- `done_o`, out, 1, one-cycle pulse; `data_o` is valid while it is high.
- `data_o`, out, `DATA_WIDTH`, working/result register.

## Operation
- State machine: IDLE, SHIFT, DONE.
- **IDLE, `start_i`=1 (accepted start)**:
  - Load `data_o` ← `data_i`, remaining ← `shamt_i`, latch `mode_i`.
  - Go to SHIFT if `shamt_i` ≠ 0, else go to DONE.
- **IDLE, `start_i`=0**: hold all registers. `data_o` keeps the last result.
- **SHIFT**, each cycle:
  - k = min(remaining, `STEP`).
  - Shift `data_o` by k per the latched mode; remaining ← remaining − k.
  - If the new remaining is 0, go to DONE.
- **Fill rules**:
  - SLL: zeros enter at the LSBs.
  - SRL: zeros enter at the MSBs.
  - SRA: copies of the current MSB enter at the MSBs; the sign is preserved across steps.
  - ROTR: the k LSBs wrap around to the MSBs.
- **DONE**: `done_o`=1 for exactly one cycle, `data_o` stable, then unconditionally return to IDLE.
- `start_i` is ignored in SHIFT and DONE. There is no queueing; the earliest next accept is the cycle after DONE.
- Latched mode and amount are immune to input changes after acceptance.
- `mode_i`/`data_i`/`shamt_i` are don't-care when `start_i` is low.

## Timing
- **Reset values** (reset low, asynchronous): state IDLE, `data_o`=0, `busy_o`=0, `done_o`=0, remaining=0.
- **Latency**: let E0 be the accepting edge and N = ceil(`shamt_i`/`STEP`). Then DONE is entered at edge E0+N, and `done_o` is high between E0+N and E0+N+1.
  - `shamt_i`=0: `done_o` is high in the cycle right after E0.
- **Throughput**: one operation per N+2 cycles (accept, N shifts, DONE) when back-to-back.
- `busy_o` and `done_o` are registered, decoded from state. `busy_o` rises at E0 and falls at E0+N+1.
- **Reset mid-operation**: aborts immediately with no `done_o` pulse; outputs take reset values.
- **Final step**: when remaining < `STEP`, only the remainder is shifted; there is never an over-shift.
- **`STEP`=`DATA_WIDTH`**: every nonzero shift completes in one SHIFT cycle.

## Test plan
- **SLL full range** (`STEP`=1): SLL, `data_i`=0x00000001, `shamt_i`=31 → `done_o` exactly at E0+31, `data_o`=0x80000000, `busy_o` high for 32 cycles.
- **Arithmetic and rotate**: SRA 0x80000000 by 4 → 0xF8000000; ROTR 0x12345678 by 8 → 0x78123456; SRL 0x80000000 by 4 → 0x08000000.
- **Zero shift**: `shamt_i`=0, `data_i`=0xDEADBEEF, any mode → `done_o` in the cycle after E0, `data_o`=0xDEADBEEF.
- **Multi-bit step** (`STEP`=4 instance): SRL 0xFFFFFFFF by 7 → 2 shift cycles (4+3), `done_o` at E0+2, `data_o`=0x01FFFFFF.
- **Start while busy**: pulse `start_i` with new operands during SHIFT and during DONE → ignored; the first result is unchanged and a single `done_o` pulse occurs.
- **Reset mid-operation**: assert `reset` low at E0+3 of a 20-bit shift → `data_o`=0, `busy_o`=0, no `done_o`. After release, a new SLL 0x3 by 1 completes with 0x6.
